// File: rtl/demux2_reg_if.sv
// demux2_reg_if
// Bundles the input stream and the two output channels of demux2_reg.
//   slave  : the demux itself. It receives in_data/in_valid/sel and the
//            consumer readies. It drives in_ready and the channel outputs.
//   master : the surrounding logic or bench, which sees the opposite directions.
// The out0_cnt/out1_cnt signals exist only when DEMUX2_REG_CNT_EN is defined.
interface demux2_reg_if #(
  parameter int IN_SIZE = 2
);
  logic [IN_SIZE-1:0] in_data;
  logic               in_valid;
  logic               sel;
  logic               in_ready;
  logic [IN_SIZE-1:0] out0_data;
  logic               out0_valid;
  logic               out0_ready;
  logic [IN_SIZE-1:0] out1_data;
  logic               out1_valid;
  logic               out1_ready;
`ifdef DEMUX2_REG_CNT_EN
  logic [7:0]         out0_cnt;
  logic [7:0]         out1_cnt;
`endif

  modport slave (
    input  in_data, in_valid, sel, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef DEMUX2_REG_CNT_EN
    , output out0_cnt, out1_cnt
`endif
  );

  modport master (
    output in_data, in_valid, sel, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef DEMUX2_REG_CNT_EN
    , input out0_cnt, out1_cnt
`endif
  );
endinterface

// File: rtl/demux2_reg.sv
// demux2_reg
// Registered 1-to-2 valid/ready stream demultiplexer. Each beat goes to
// channel 0 or 1 according to sel at the moment of transfer. Each channel
// has its own one-entry holding register, so a stalled consumer only blocks
// the input while sel points at its channel.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset. It empties both channels and clears
//        data and counters. in_ready is held low while rst is high.
//   bus  demux2_reg_if.slave (in_data, in_valid, sel, in_ready,
//        outK_data, outK_valid, outK_ready, and optionally outK_cnt)
// Optional feature: define DEMUX2_REG_CNT_EN to add 8-bit wrapping
// accepted-beat counters per channel (out0_cnt, out1_cnt).
//
// Channel FSM (one per channel):
//   state | meaning
//   EMPTY | holding register has no beat, outK_valid = 0
//   FULL  | holding register has a beat, outK_valid = 1
module demux2_reg #(
  parameter int IN_SIZE = 2
) (
  input  logic         clk,
  input  logic         rst,
  demux2_reg_if.slave  bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q [2];
  state_t             state_d [2];
  logic [IN_SIZE-1:0] data_q  [2];
  logic [1:0]         load;
  logic [1:0]         drain;
  logic [1:0]         out_ready;
  logic               sel_ready;
  logic               in_ready;
  logic               in_xfer;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // Only the selected channel matters for in_ready. A full channel can still
  // accept a beat when its consumer drains it in the same cycle.
  always_comb begin
    sel_ready = 1'b0;
    if (bus.sel) sel_ready = (state_q[1] == EMPTY) || bus.out1_ready;
    else         sel_ready = (state_q[0] == EMPTY) || bus.out0_ready;
  end

  assign in_ready = !rst && sel_ready;
  assign in_xfer  = bus.in_valid && in_ready;
  assign load     = {in_xfer && bus.sel, in_xfer && !bus.sel};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      drain[k]   = (state_q[k] == FULL) && out_ready[k];
      case (state_q[k])
        EMPTY:   if (load[k]) state_d[k] = FULL;
        FULL:    if (drain[k] && !load[k]) state_d[k] = EMPTY;
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end else begin
        state_q[k] <= state_d[k];
        if (load[k]) data_q[k] <= bus.in_data;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_data  = data_q[0];
  assign bus.out1_data  = data_q[1];
  assign bus.out0_valid = (state_q[0] == FULL);
  assign bus.out1_valid = (state_q[1] == FULL);

`ifdef DEMUX2_REG_CNT_EN
  logic [7:0] cnt_q [2];

  // Counts accepted beats, not drained ones, and wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst)          cnt_q[k] <= '0;
      else if (load[k]) cnt_q[k] <= cnt_q[k] + 8'd1;
    end
  end

  assign bus.out0_cnt = cnt_q[0];
  assign bus.out1_cnt = cnt_q[1];
`endif
endmodule
